// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator and its consumers.
// The generator owns every signal except pixel_tick, which the consumer or clock-enable logic drives.
interface vga_sync_gen_if;
  logic       pixel_tick;
  logic       hsync;
  logic       vsync;
  logic       video_enable;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       line_start;
  logic       frame_start;
  logic [5:0] frame_count;

  modport master (
    input  pixel_tick,
    output hsync, vsync, video_enable, h_count, v_count,
           line_start, frame_start, frame_count
  );

  modport slave (
    output pixel_tick,
    input  hsync, vsync, video_enable, h_count, v_count,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: position counters, sync pulses, one-cycle strobes and a frame counter.
// Every output is a register; decodes are taken on the position being entered, so they line up with it.
module vga_sync_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic           pixel_clk,
  input  logic           reset_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       ven_q, ven_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic [5:0] fc_q, fc_d;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    ven_d   = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;
    if (vga.pixel_tick) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Syncs are XORed with the polarity so one compare serves both conventions.
      ven_d   = (h_d < H_VIS) && (v_d < V_VIS);
      hsync_d = ((h_d >= HS_BEG) && (h_d < HS_END)) ^ SYNC_ACTIVE_LOW;
      vsync_d = ((v_d >= VS_BEG) && (v_d < VS_END)) ^ SYNC_ACTIVE_LOW;
      ls_d    = (h_d == 10'd0);
      fs_d    = (h_d == 10'd0) && (v_d == 10'd0);
      if (fs_d) begin
        fc_d = fc_q + 6'd1;
      end
    end
  end

  // Reset parks one position before (0,0) and one frame before 0, so the first tick starts frame 0.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hsync_q <= SYNC_ACTIVE_LOW;
      vsync_q <= SYNC_ACTIVE_LOW;
      ven_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 6'h3F;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ven_q   <= ven_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign vga.h_count      = h_q;
  assign vga.v_count      = v_q;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.video_enable = ven_q;
  assign vga.line_start   = ls_q;
  assign vga.frame_start  = fs_q;
  assign vga.frame_count  = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench for vga_sync_gen on a shrunken raster so many whole frames fit in a short run.
// A frame-linear position model pushes expectations on every edge; a monitor pops and compares.
module tb_vga_sync_gen;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit ven;
    bit ls;
    bit fs;
    int fc;
  } exp_t;

  logic pixel_clk;
  logic reset_n = 1'b0;
  vga_sync_gen_if vga ();

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset_n  (reset_n),
    .vga      (vga)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   pos    = FRAME - 1;   // linear pixel index within the frame
  int   frames = -1;          // frames started since reset

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a single linear position, split into (h,v) by division.
  always @(posedge pixel_clk or negedge reset_n) begin
    exp_t e;
    bit   adv;
    adv = 1'b0;
    if (!reset_n) begin
      pos    = FRAME - 1;
      frames = -1;
    end else if (vga.pixel_tick) begin
      adv = 1'b1;
      pos = (pos + 1) % FRAME;
      if (pos == 0) frames++;
    end
    e.h   = pos % HT;
    e.v   = pos / HT;
    e.ven = adv && (e.h < HA) && (e.v < VA);
    e.ls  = adv && (e.h == 0);
    e.fs  = adv && (pos == 0);
    e.hs  = !((e.h >= HA + HF) && (e.h < HA + HF + HS));
    e.vs  = !((e.v >= VA + VF) && (e.v < VA + VF + VS));
    e.fc  = frames & 63;
    exp_q.push_back(e);
  end

  always @(posedge pixel_clk or negedge reset_n) begin
    exp_t e;
    #2;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
    end else begin
      checks--;
      e = exp_q.pop_front();
      chk("h_count",      vga.h_count,      e.h);
      chk("v_count",      vga.v_count,      e.v);
      chk("hsync",        vga.hsync,        e.hs);
      chk("vsync",        vga.vsync,        e.vs);
      chk("video_enable", vga.video_enable, e.ven);
      chk("line_start",   vga.line_start,   e.ls);
      chk("frame_start",  vga.frame_start,  e.fs);
      chk("frame_count",  vga.frame_count,  e.fc);
    end
  end

  initial begin
    int n_ven, n_ls, n_fs, n_hlo, n_vlo, guard;
    bit found;
    n_ven = 0; n_ls = 0; n_fs = 0; n_hlo = 0; n_vlo = 0;
    vga.pixel_tick = 1'b0;
    repeat (3) @(negedge pixel_clk);

    // One whole frame with the tick held high, tallying strobes and sync pulses.
    reset_n = 1'b1;
    vga.pixel_tick = 1'b1;
    repeat (FRAME) begin
      @(negedge pixel_clk);
      n_ven += int'(vga.video_enable);
      n_ls  += int'(vga.line_start);
      n_fs  += int'(vga.frame_start);
      n_hlo += int'(!vga.hsync);
      n_vlo += int'(!vga.vsync);
    end
    chk("ven_per_frame",   n_ven, HA * VA);
    chk("ls_per_frame",    n_ls,  VT);
    chk("fs_per_frame",    n_fs,  1);
    chk("hsync_low_cycles", n_hlo, HS * VT);
    chk("vsync_low_cycles", n_vlo, VS * HT);

    // Alternating tick.
    for (int i = 0; i < 40; i++) begin
      vga.pixel_tick = (i % 2 == 0);
      @(negedge pixel_clk);
    end

    // Random tick until the frame counter has wrapped past 63 back to 0 and 1.
    guard = 0;
    while (frames < 66 && guard < 60000) begin
      vga.pixel_tick = ($urandom_range(3) != 0);
      @(negedge pixel_clk);
      guard++;
    end
    chk("frame_wrap_reached", int'(frames >= 66), 1);

    // Run to an active-area pixel, then hit reset asynchronously between edges.
    found = 1'b0;
    vga.pixel_tick = 1'b1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge pixel_clk);
      if (pos == 3 * HT + 5) found = 1'b1;
    end
    chk("reach_mid_active", int'(found), 1);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge pixel_clk);
    reset_n = 1'b1;
    repeat (30) @(negedge pixel_clk);

    repeat (2) @(negedge pixel_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA raster timing from a single pixel clock and drives the active-area enable that the frame buffer sync stage counts. Sits directly upstream of the frame buffer sync/controller path and drives the pad-level hsync/vsync. Maintains horizontal and vertical position counters, qualifies them with an optional pixel tick, and emits one-cycle line and frame strobes plus a wrapping frame counter for animation timing.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync driven low during pulse
- pixel_clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pixel_tick  in  1  advance enable; tie high for 1 pixel per clock
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_enable  out  1  one-cycle strobe per active pixel
- h_count  out  10  current horizontal position, 0..H_TOTAL-1
- v_count  out  10  current vertical position, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe when h_count becomes 0
- frame_start  out  1  one-cycle strobe when (h_count,v_count) becomes (0,0)
- frame_count  out  6  frames started since reset, modulo 64

## Operation

- All outputs registered; no combinational path from inputs to outputs.
- Reset (reset_n low, asynchronous): h_count = H_TOTAL-1 (799), v_count = V_TOTAL-1 (524), hsync/vsync inactive level (1 when SYNC_ACTIVE_LOW), video_enable = 0, line_start = 0, frame_start = 0, frame_count = 6'h3F.
- Advance: on a rising edge with pixel_tick = 1, h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments; v_count at V_TOTAL-1 wraps to 0. So the first advancing edge after reset presents (0,0).
- pixel_tick = 0: h_count, v_count, hsync, vsync, frame_count hold; all three strobes are 0.
- Decodes, evaluated on the position being presented after the advancing edge:
  - video_enable = h_count < H_ACTIVE and v_count < V_ACTIVE
  - hsync active when H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC (656..751)
  - vsync active when V_ACTIVE+V_FRONT <= v_count < V_ACTIVE+V_FRONT+V_SYNC (490..491); the level changes on the same edge h_count wraps to 0
  - line_start = h_count == 0; frame_start = h_count == 0 and v_count == 0
- Strobes (video_enable, line_start, frame_start) are high for exactly one pixel_clk cycle after each advancing edge, never on non-advancing cycles. Downstream counters can therefore count video_enable cycles directly.
- frame_count increments (mod 64) on the edge that asserts frame_start. The first frame after reset reads 0.
- Counters use exact compare-and-wrap; no values ≥ H_TOTAL / V_TOTAL are ever presented.

## Timing

- Latency: position change visible on outputs one edge after the sampled pixel_tick = 1.
- Per frame with pixel_tick held high: 800 × 525 = 420000 cycles; 307200 video_enable strobes; 525 line_start; 1 frame_start.
- hsync pulse 96 cycles per line. vsync pulse 2 full lines (1600 cycles).
- Reset asserted mid-frame: outputs take reset values immediately (asynchronously). Restart from (0,0) on the first advancing edge after release.
- reset_n release is assumed synchronised externally to pixel_clk.

## Test plan

- Reset release, pixel_tick = 1: first edge gives h_count = 0, v_count = 0, video_enable = 1, line_start = 1, frame_start = 1, frame_count = 0. Second edge gives h_count = 1 and all strobes 0 except video_enable.
- Full frame, tick high: count exactly 307200 video_enable, 525 line_start, 1 frame_start over 420000 cycles. hsync low for h_count 656..751. vsync low for v_count 490..491.
- Wrap corner: at (799,479) the next edge gives (0,480) with video_enable = 0. At (799,524) the next edge gives (0,0) and frame_count increments.
- pixel_tick toggled 1,0,1,0: counters advance every other cycle. Strobes appear only in cycles after an advancing edge. sync levels hold across idle cycles.
- reset_n pulsed low mid-active-area (e.g. at (300,200)): outputs immediately show (799,524) with inactive syncs. Restart at (0,0) after release, and frame_count restarts at 0.
- 64 frames run: frame_count reads 0..63 and returns to 0 on frame 65.
